// File: rtl/fp_mul_arbiter.sv
// ============================================================================
// fp_mul_arbiter : round-robin arbiter sharing one combinational FP multiplier
//                  among NUM_REQ requesters, one operation in flight at a time.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_prod,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      ops_done
);

  localparam int c_ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_ID_W-1:0]   r_rr_ptr;
  logic [c_ID_W-1:0]   r_gnt_id;
  logic [31:0]         r_op_a;
  logic [31:0]         r_op_b;
  logic [31:0]         r_res;
  logic [CNT_W-1:0]    r_ops_done;

  logic                w_found;
  logic [c_ID_W-1:0]   w_win;
  logic [c_ID_W:0]     w_idx;
  logic [31:0]         w_sel_a;
  logic [31:0]         w_sel_b;
  logic                w_accept;
  logic                w_done;
  logic [c_ID_W-1:0]   w_ptr_nxt;

  // Scan from the highest index down so the entry closest to r_rr_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_rr_ptr} + (c_ID_W + 1)'(k);
      if (w_idx >= (c_ID_W + 1)'(NUM_REQ)) begin
        w_idx = w_idx - (c_ID_W + 1)'(NUM_REQ);
      end
      if (req_valid[w_idx[c_ID_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[c_ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == c_ID_W'(i)) begin
        w_sel_a = req_a[32*i +: 32];
        w_sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept    = 1'b1;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[r_gnt_id]) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_ptr_nxt = (r_gnt_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + c_ID_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_res      <= '0;
      r_ops_done <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_op_a   <= w_sel_a;
        r_op_b   <= w_sel_b;
        r_gnt_id <= w_win;
      end
      if (r_state == S_MUL) begin
        r_res <= mul_prod;
      end
      if (w_done) begin
        r_rr_ptr   <= w_ptr_nxt;
        r_ops_done <= r_ops_done + CNT_W'(1);
      end
    end
  end

  // Grant is masked during reset so no requester sees a phantom handshake.
  assign req_ready = (reset_n && (r_state == S_IDLE) && w_found) ?
                     (NUM_REQ'(1) << w_win) : '0;
  assign rsp_valid = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gnt_id) : '0;
  assign rsp_data  = r_res;
  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign busy      = (r_state != S_IDLE);
  assign ops_done  = r_ops_done;

endmodule

`default_nettype wire

// File: tb/tb_fp_mul_arbiter.sv
// ============================================================================
// tb_fp_mul_arbiter : scoreboard bench for fp_mul_arbiter (4 requesters, 4-bit
//                     counter so the completed-operation count wraps).
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fp_mul_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;

  logic            clock   = 1'b0;
  logic            reset_n = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  logic [31:0]     mul_prod;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [31:0]     rsp_data;
  logic            busy;
  logic [CW-1:0]   ops_done;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_busy;
  int          m_age;
  int          m_id;
  int          m_ptr;
  int          m_cnt;
  logic [31:0] m_a;
  logic [31:0] m_b;

  fp_mul_arbiter #(.NUM_REQ(N), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_prod  (mul_prod),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .ops_done  (ops_done)
  );

  always #5 clock = ~clock;

  // Truncating single-precision multiply for normal operands.
  function automatic logic [31:0] fpmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127;
    if (m[47]) return {s, e[7:0] + 8'd1, m[46:24]};
    return {s, e[7:0], m[45:23]};
  endfunction

  assign mul_prod = fpmul(mul_a, mul_b);

  function automatic logic [31:0] rand_op();
    return {1'($urandom), 8'($urandom_range(100, 154)), 23'($urandom)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_age  = 0;
    m_id   = 0;
    m_ptr  = 0;
    m_cnt  = 0;
    m_a    = '0;
    m_b    = '0;
    exp_q.delete();
  endtask

  // Transaction-level reference: priority scan from the pointer, one op in flight.
  always @(negedge clock) begin
    if (mon_en) begin
      logic [N-1:0] exp_rdy;
      logic [N-1:0] exp_rv;
      int           win;
      bit           found;
      if (m_busy) m_age++;
      exp_rdy = '0;
      found   = 1'b0;
      win     = 0;
      if (!m_busy) begin
        for (int k = 0; k < N; k++) begin
          if (!found && req_valid[(m_ptr + k) % N]) begin
            found = 1'b1;
            win   = (m_ptr + k) % N;
          end
        end
      end
      if (found) exp_rdy = N'(1) << win;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_busy));
      check("ops_done", 32'(ops_done), 32'(m_cnt % (1 << CW)));
      exp_rv = (m_busy && m_age >= 2) ? (N'(1) << m_id) : '0;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (m_busy) begin
        check("mul_a", mul_a, m_a);
        check("mul_b", mul_b, m_b);
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
        end else begin
          check("rsp_data", rsp_data, exp_q[0].data);
          if (rsp_valid[exp_q[0].id] && rsp_ready[exp_q[0].id]) begin
            m_ptr  = (exp_q[0].id + 1) % N;
            m_cnt++;
            m_busy = 1'b0;
            void'(exp_q.pop_front());
          end
        end
      end
      if (found) begin
        m_a = req_a[32*win +: 32];
        m_b = req_b[32*win +: 32];
        exp_q.push_back('{win, fpmul(m_a, m_b)});
        m_busy = 1'b1;
        m_age  = 0;
        m_id   = win;
      end
    end
  end

  // One directed operation: optional k-cycle response stall and a competing requester.
  task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int k, input int other);
    logic [N-1:0] oh;
    int           cnt;
    oh = N'(1) << id;
    req_a[32*id +: 32] = a;
    req_b[32*id +: 32] = b;
    rsp_ready = (k == 0) ? '1 : ~oh;
    req_valid = oh | ((other >= 0) ? (N'(1) << other) : '0);
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (!req_ready[id] && cnt < 10);
    check("grant", 32'(req_ready), 32'(oh));
    tick();
    req_valid[id] = 1'b0;
    req_a[32*id +: 32] = rand_op();
    req_b[32*id +: 32] = rand_op();
    @(negedge clock);
    check("mul_phase_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mul_phase_req_ready", 32'(req_ready), 32'd0);
    tick();
    for (int s = 0; s < k; s++) begin
      @(negedge clock);
      check("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("stall_rsp_data", rsp_data, exp);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = '1;
    @(negedge clock);
    check("resp_valid", 32'(rsp_valid), 32'(oh));
    check("resp_data", rsp_data, exp);
    tick();
    if (other >= 0) begin
      @(negedge clock);
      check("next_grant", 32'(req_ready), 32'(N'(1) << other));
      tick();
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] ra;
    logic [31:0] rb;
    req_valid = '0;
    rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = rand_op();
      req_b[32*i +: 32] = rand_op();
    end
    model_reset();

    // Reset values, with every requester asking while reset is held.
    #2 reset_n = 1'b0;
    req_valid = '1;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_mul_a", mul_a, 32'd0);
    check("rst_mul_b", mul_b, 32'd0);
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    req_valid = '0;
    mon_en = 1'b1;
    tick();

    // Round robin: grants 0,1,2,3,0 spaced three cycles apart.
    req_valid = '1;
    rsp_ready = '1;
    for (int g = 0; g < 5; g++) begin
      cnt = 0;
      do begin
        @(negedge clock);
        cnt++;
      end while (req_ready == '0 && cnt < 20);
      check("rr_grant", 32'(req_ready), 32'(N'(1) << (g % N)));
      if (g > 0) check("rr_spacing", 32'(cnt), 32'd3);
    end
    tick();
    req_valid = '0;
    repeat (4) tick();

    do_op(1, 32'h40400000, 32'h40000000, 32'h40C00000, 0, -1);
    repeat (2) tick();

    ra = rand_op();
    rb = rand_op();
    do_op(2, ra, rb, fpmul(ra, rb), 5, 3);
    req_valid = '0;
    repeat (4) tick();

    do_op(0, 32'hC0800000, 32'h3F000000, 32'hC0000000, 1, -1);
    repeat (2) tick();

    // Random traffic; with a 4-bit counter this wraps ops_done many times.
    for (int c = 0; c < 600; c++) begin
      req_valid = N'($urandom);
      rsp_ready = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_a[32*i +: 32] = rand_op();
        req_b[32*i +: 32] = rand_op();
      end
      tick();
    end
    req_valid = '0;
    rsp_ready = '1;
    repeat (5) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset while a response is pending discards it.
    req_valid = N'(1);
    rsp_ready = '0;
    cnt = 0;
    do begin
      @(negedge clock);
      cnt++;
    end while (rsp_valid == '0 && cnt < 20);
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_data", rsp_data, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ops_done", 32'(ops_done), 32'd0);
    check("mid_rst_mul_a", mul_a, 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    req_valid = '1;
    rsp_ready = '1;
    @(posedge clock);
    #3 reset_n = 1'b1;
    model_reset();
    mon_en = 1'b1;
    #1;
    check("first_after_reset", 32'(req_ready), 32'd1);
    repeat (12) tick();
    req_valid = '0;
    repeat (5) tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);
    mon_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fp_mul_arbiter.md
# fp_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational single-precision floating-point multiplier among `NUM_REQ` requesters, typically the convolution and dense-layer engines of the CNN.
- Accepts one operand pair at a time over a valid/ready handshake and drives the pair onto the shared multiplier.
- Registers the packed result and returns it to the granted requester over a valid/ready response channel.
- Only one operation is in flight at a time. It sits between the layer engines and the `fpMul` instance.

## Interface

Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CNT_W`, 16: width of the completed-operation counter.

Ports:
- `clock`, input, 1: single clock; all state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, NUM_REQ: per-requester operand-pair valid.
- `req_ready`, output, NUM_REQ: per-requester grant; at most one bit high.
- `req_a`, input, 32*NUM_REQ: operand A of requester i at bits [32i+31:32i], IEEE-754 single.
- `req_b`, input, 32*NUM_REQ: operand B of requester i, same packing as `req_a`.
- `mul_a`, output, 32: operand A to the shared multiplier.
- `mul_b`, output, 32: operand B to the shared multiplier.
- `mul_prod`, input, 32: multiplier result, packed by the parent as {sign, exponent[7:0], prod[22:0]}; combinational from `mul_a`/`mul_b`.
- `rsp_valid`, output, NUM_REQ: one-hot response valid to the granted requester.
- `rsp_ready`, input, NUM_REQ: per-requester response accept.
- `rsp_data`, output, 32: registered product.
- `busy`, output, 1: high in MUL and RESP.
- `ops_done`, output, CNT_W: count of completed operations; wraps modulo 2^CNT_W.

## Operation

Internal state:
- `state` ∈ {IDLE, MUL, RESP}.
- `rr_ptr` (highest-priority index).
- `gnt_id`, `op_a`, `op_b`, `res`.

IDLE:
- The winner is the first i with `req_valid[i]` high, scanning `rr_ptr`, `rr_ptr`+1, … modulo NUM_REQ.
- `req_ready[winner]` is high, computed combinationally from `req_valid` and `rr_ptr`. All other bits of `req_ready` are 0.
- When no `req_valid` is high, `req_ready` is all zero.
- On handshake (`req_valid[i]` & `req_ready[i]`):
  - `op_a`/`op_b` <= `req_a`/`req_b` slice i.
  - `gnt_id` <= i.
  - `state` <= MUL.

MUL:
- `req_ready` is 0.
- `res` <= `mul_prod`; `state` <= RESP.

RESP:
- `rsp_valid[gnt_id]` = 1; `rsp_data` = `res`; `req_ready` is 0.
- Hold until `rsp_ready[gnt_id]` is high, then:
  - `state` <= IDLE.
  - `rr_ptr` <= (`gnt_id`+1) mod NUM_REQ.
  - `ops_done` <= `ops_done`+1.
- `rsp_ready` bits other than `gnt_id` are ignored.

Outputs in all states:
- `mul_a` = `op_a` and `mul_b` = `op_b` (registered, glitch-free to the multiplier).
- `res`, `rsp_data`, `gnt_id`, `op_a` and `op_b` keep their values while in IDLE.

Requester rules:
- Requesters may drop `req_valid` before a handshake without effect.
- Operands need not stay stable after the handshake.
- `rr_ptr` changes only on response completion. A requester that keeps `req_valid` high is served at most once per NUM_REQ grants while others are requesting.

## Timing

Reset (async assert, sync-effective release):
- `state`=IDLE, `rr_ptr`=0, `gnt_id`=0.
- `op_a`, `op_b`, `res`, `mul_a`, `mul_b`, `rsp_data` = 0.
- `rsp_valid`=0, `busy`=0, `ops_done`=0.
- `req_ready` follows the IDLE rule combinationally once `reset_n` is high. It is forced to 0 while `reset_n` is low.
- Reset asserted mid-operation discards the in-flight op; no response is produced.

Latency and throughput:
- Handshake sampled at the end of cycle C: MUL is cycle C+1 and `rsp_valid` is high from cycle C+2.
- `rsp_ready` already high in C+2: next handshake is possible in C+3, giving a minimum of 3 cycles per operation.
- A response stalled for k cycles adds k cycles.

Other rules:
- A simultaneous `req_valid` change and reset gives reset priority.
- `ops_done` wraps from 2^CNT_W−1 to 0 with no flag.

## Test plan

1. **Reset values:** assert `reset_n`=0 mid-RESP → all outputs take their reset values immediately. After release, the first request from requester 0 is granted.
2. **Single op and latency:** requester 1 sends A=0x40400000 (3.0), B=0x40000000 (2.0) through a fpMul-equivalent model → `rsp_valid`=4'b0010 in C+2, `rsp_data`=0x40C00000, `ops_done`=1.
3. **Round-robin fairness:** all four requesters hold `req_valid` high with `rsp_ready` tied high → grant order 0,1,2,3,0; one grant every 3 cycles.
4. **Response backpressure:** `rsp_ready` held low for 5 cycles in RESP → `rsp_valid` and `rsp_data` stay stable, `req_ready` stays 0, and the next grant is delayed by 5 cycles. A `rsp_ready` on a non-granted bit is ignored.
5. **Sign handling:** A=0xC0800000 (−4.0), B=0x3F000000 (0.5) → `rsp_data`=0xC0000000. Operand inputs changed the cycle after the handshake do not alter the result.
6. **Counter wrap:** with `CNT_W`=4, run 17 ops → `ops_done`=1.
